// File: rtl/romix_pkg.sv
// Shared constants, FSM state type and word byte-swap helper for the ROMix engine.
package romix_pkg;

    localparam int BLOCK_W        = 1024;
    localparam int WORD_W         = 32;
    localparam int NUM_WORDS      = BLOCK_W / WORD_W;
    localparam int INTEGERIFY_LSB = 480;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P1_ST = 3'd1,
        P1_WT = 3'd2,
        P2_RD = 3'd3,
        P2_XR = 3'd4,
        P2_ST = 3'd5,
        P2_WT = 3'd6,
        DONE  = 3'd7
    } romix_state_t;

    // Reverses the byte order inside every 32-bit word; word positions are untouched.
    function automatic logic [BLOCK_W-1:0] word_bswap(input logic [BLOCK_W-1:0] b);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            r[w*WORD_W +: WORD_W] = {b[w*WORD_W +: 8], b[w*WORD_W + 8 +: 8],
                                     b[w*WORD_W + 16 +: 8], b[w*WORD_W + 24 +: 8]};
        end
        return r;
    endfunction

endpackage

// File: rtl/romix_if.sv
// Host start/result handshake plus the BlockMix request/response pair.
interface romix_if;
    import romix_pkg::*;

    logic               init;
    logic [BLOCK_W-1:0] in;
    logic [BLOCK_W-1:0] out;
    logic               valid;
    logic               bm_init;
    logic [BLOCK_W-1:0] bm_in;
    logic [BLOCK_W-1:0] bm_out;
    logic               bm_valid;

    // master: host + BlockMix side; slave: the ROMix core
    modport master (output init, in, bm_out, bm_valid,
                    input  out, valid, bm_init, bm_in);
    modport slave  (input  init, in, bm_out, bm_valid,
                    output out, valid, bm_init, bm_in);
endinterface

// File: rtl/romix_scratchpad.sv
// N x BLOCK_W simple dual-port RAM for the V array: sync write, registered read, no reset.
module romix_scratchpad
    import romix_pkg::*;
#(
    parameter int N      = 1024,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [BLOCK_W-1:0] rd_data
);

    logic [BLOCK_W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/romix_core.sv
// Sequential scrypt ROMix (r=1) around one external BlockMix; owns the V scratchpad.
// Optional ROMIX_ENDIAN_SWAP_EN: byte-swap each word of in/out at the boundary.
module romix_core
    import romix_pkg::*;
#(
    parameter int N      = 1024,
    parameter int ADDR_W = $clog2(N)
) (
    input logic   clk,
    input logic   reset,
    romix_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    romix_state_t       state;
    logic [BLOCK_W-1:0] x;
    logic [ADDR_W-1:0]  i;
    logic               bm_init_q;
    logic               valid_q;

    logic               wr_en;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [BLOCK_W-1:0] rd_data;
    logic [BLOCK_W-1:0] in_int;

    assign wr_en   = (state == P1_ST);
    assign rd_en   = (state == P2_RD);
    assign rd_addr = x[INTEGERIFY_LSB +: ADDR_W];

`ifdef ROMIX_ENDIAN_SWAP_EN
    assign in_int  = word_bswap(bus.in);
    assign bus.out = word_bswap(x);
`else
    assign in_int  = bus.in;
    assign bus.out = x;
`endif

    assign bus.bm_in   = x;
    assign bus.bm_init = bm_init_q;
    assign bus.valid   = valid_q;

    romix_scratchpad #(.N(N), .ADDR_W(ADDR_W)) u_spad (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (i),
        .wr_data (x),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // bm_init and valid are raised on the transition into P*_ST / DONE so they
    // are high exactly during those states while still coming from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            i         <= '0;
            bm_init_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            bm_init_q <= 1'b0;
            valid_q   <= 1'b0;
            unique case (state)
                IDLE: if (bus.init) begin
                    x         <= in_int;
                    i         <= '0;
                    bm_init_q <= 1'b1;
                    state     <= P1_ST;
                end
                P1_ST: state <= P1_WT;
                P1_WT: if (bus.bm_valid) begin
                    x <= bus.bm_out;
                    if (i == LAST) begin
                        i     <= '0;
                        state <= P2_RD;
                    end else begin
                        i         <= i + 1'b1;
                        bm_init_q <= 1'b1;
                        state     <= P1_ST;
                    end
                end
                P2_RD: state <= P2_XR;
                P2_XR: begin
                    x         <= x ^ rd_data;
                    bm_init_q <= 1'b1;
                    state     <= P2_ST;
                end
                P2_ST: state <= P2_WT;
                P2_WT: if (bus.bm_valid) begin
                    x <= bus.bm_out;
                    if (i == LAST) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        i     <= i + 1'b1;
                        state <= P2_RD;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
